alu_opnd_stage: RTL

Parametrised operand-preparation pipeline stage between register-file read and the ALU. Each cycle it can accept one instruction's operands. It forms ALU operand A from the rd value and operand B from rs or an extended immediate, with write-back forwarding for both register operands. Results are held in a registered output stage with a valid/ready handshake and a one-entry skid buffer, so ALU back-pressure never drops or duplicates an operand pair.

---
 rtl/alu_opnd_stage.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu_opnd_stage.sv
// alu_opnd_stage
//   Operand-preparation stage between register-file read and the ALU.
//   Builds operand A from rd and operand B from rs or an extended immediate. Both register
//   operands see write-back forwarding. Results sit in a registered output stage with a
//   valid/ready handshake and a one-entry skid buffer, so ALU back-pressure never drops or
//   duplicates a pair.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  upstream handshake; in_ready is NOT skid_valid
//   rd_q, rs_q           register-file read values
//   rd_addr, rs_addr     register indices used for the forwarding compare
//   offset, b_sel        immediate field and operand-B mode
//                        (00 zext, 01 sext, 10 rs, 11 offset in the upper bits)
//   wb_en/addr/data      write-back bus, forwarded into operands at acceptance
//   out_valid/out_ready  ALU handshake
//   alu_a, alu_b         registered operand pair
module alu_opnd_stage #(
    parameter int unsigned DW = 16,
    parameter int unsigned OW = 8,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] rd_q,
    input  logic [DW-1:0] rs_q,
    input  logic [AW-1:0] rd_addr,
    input  logic [AW-1:0] rs_addr,
    input  logic [OW-1:0] offset,
    input  logic [1:0]    b_sel,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b
);

    logic          out_valid_q, out_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic [DW-1:0] skid_a_q, skid_a_d;
    logic [DW-1:0] skid_b_q, skid_b_d;

    logic          in_xfer, out_xfer;
    logic [DW-1:0] a_val, rs_val, b_val;

    assign in_ready  = ~skid_valid_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid_q & out_ready;
    assign out_valid = out_valid_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;

    // Forwarding: write-back data wins over the register-file read, including index 0.
    always_comb begin
        a_val  = (wb_en && (wb_addr == rd_addr)) ? wb_data : rd_q;
        rs_val = (wb_en && (wb_addr == rs_addr)) ? wb_data : rs_q;
    end

    // Operand B. Writing offset into a sub-range of a pre-filled vector keeps the OW == DW
    // case legal: all immediate modes then collapse to offset unchanged.
    always_comb begin
        b_val = '0;
        unique case (b_sel)
            2'b00: begin
                b_val            = '0;
                b_val[OW-1:0]    = offset;
            end
            2'b01: begin
                b_val            = {DW{offset[OW-1]}};
                b_val[OW-1:0]    = offset;
            end
            2'b10: begin
                b_val            = rs_val;
            end
            default: begin
                b_val            = '0;
                b_val[DW-1:DW-OW] = offset;
            end
        endcase
    end

    // Output stage: EMPTY (!out_valid), FULL (out_valid, !skid_valid), SKID (both).
    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        skid_a_d     = skid_a_q;
        skid_b_d     = skid_b_q;

        if (!out_valid_q) begin
            if (in_xfer) begin
                out_valid_d = 1'b1;
                alu_a_d     = a_val;
                alu_b_d     = b_val;
            end
        end else if (!skid_valid_q) begin
            if (in_xfer && out_xfer) begin
                alu_a_d = a_val;
                alu_b_d = b_val;
            end else if (in_xfer) begin
                // ALU stalled: park the new pair so upstream never has to retract it.
                skid_valid_d = 1'b1;
                skid_a_d     = a_val;
                skid_b_d     = b_val;
            end else if (out_xfer) begin
                out_valid_d = 1'b0;
            end
        end else begin
            // in_ready is low here, so only a drain can happen.
            if (out_xfer) begin
                skid_valid_d = 1'b0;
                alu_a_d      = skid_a_q;
                alu_b_d      = skid_b_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            skid_a_q     <= '0;
            skid_b_q     <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            skid_a_q     <= skid_a_d;
            skid_b_q     <= skid_b_d;
        end
    end

endmodule
